// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory read outstanding and
// buffers returned words in a 2-entry queue feeding decode.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic [15:0] Instr,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  localparam int unsigned XW = 16;
  localparam int unsigned OW = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SQUASH = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic [XW-1:0] instr;
    logic [XW-1:0] pc2;
  } entry_t;

  state_e        state_q, state_d;
  logic [XW-1:0] fetch_pc_q, fetch_pc_d;
  logic          rd_q, rd_d;
  logic [XW-1:0] addr_q, addr_d;
  logic          halted_q, halted_d;
  entry_t        e0_q, e0_d, e1_q, e1_d;
  logic          v0_q, v0_d, v1_q, v1_d;

  logic          outstanding;
  logic          pop;
  logic          push;
  logic          push_halt;
  logic [OW-1:0] occ_cur;
  logic [OW-1:0] occ_post;
  logic          issue_ok;
  logic          issue;
  logic [XW-1:0] target_pc;
  logic [XW-1:0] issue_pc;
  entry_t        new_entry;
  entry_t        empty_head;

  // Handshake qualifiers; redirect suppresses both pop and push.
  assign outstanding = (state_q == S_WAIT) || (state_q == S_SQUASH);
  assign pop         = v0_q && !id_stall && !redirect;
  assign push        = (state_q == S_WAIT) && imem_done && !redirect;
  assign push_halt   = push && (imem_rdata[15:11] == 5'b00000);
  assign occ_cur     = OW'(v0_q) + OW'(v1_q);
  assign occ_post    = redirect ? OW'(0) : OW'(occ_cur - OW'(pop) + OW'(push));
  assign issue_ok    = (occ_post <= OW'(1));
  assign target_pc   = redirect_pc & ~XW'(1);
  assign issue_pc    = redirect ? target_pc : fetch_pc_q;
  assign new_entry   = '{instr: imem_rdata, pc2: XW'(addr_q + XW'(2))};
  assign empty_head  = '{instr: NOP_INSTR, pc2: XW'(0)};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and issue decision.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (redirect) begin
      unique case (state_q)
        S_WAIT, S_SQUASH: begin
          if (imem_done) begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_SQUASH;
          end
        end
        S_IDLE: begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue_ok) begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_done) begin
            if (push_halt) begin
              state_d = S_HALTED;
            end else if (issue_ok) begin
              issue   = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_SQUASH: begin
          if (imem_done) begin
            if (issue_ok) begin
              issue   = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Request, PC, halt flag and queue next values.
  always_comb begin
    rd_d       = rd_q;
    addr_d     = addr_q;
    fetch_pc_d = redirect ? target_pc : fetch_pc_q;
    halted_d   = halted_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    v0_d       = v0_q;
    v1_d       = v1_q;

    if (redirect)       halted_d = 1'b0;
    else if (push_halt) halted_d = 1'b1;

    if (issue) begin
      rd_d       = 1'b1;
      addr_d     = issue_pc;
      fetch_pc_d = XW'(issue_pc + XW'(2));
    end else if (outstanding && imem_done) begin
      rd_d = 1'b0;
    end

    if (pop) begin
      e0_d = e1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
    end
    if (push) begin
      if (!v0_d) begin
        e0_d = new_entry;
        v0_d = 1'b1;
      end else begin
        e1_d = new_entry;
        v1_d = 1'b1;
      end
    end
    if (redirect) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end

    // Empty slots hold a canonical value so the head can drive decode directly.
    if (!v0_d) e0_d = empty_head;
    if (!v1_d) e1_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
      e0_q       <= '{instr: NOP_INSTR, pc2: XW'(0)};
      e1_q       <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
    end
  end

  assign imem_rd     = rd_q;
  assign imem_addr   = addr_q;
  assign Instr       = e0_q.instr;
  assign pc_plus2    = e0_q.pc2;
  assign instr_valid = v0_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a negedge-driven instruction memory model
// whose data is the address XOR 16'hA500 (optionally HALT at address 6).
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic [15:0] Instr;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        id_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  int checks  = 0;
  int errors  = 0;
  int mem_lat = 0;
  int lat_cnt = 0;
  bit halt_en = 1'b0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_done   (imem_done),
    .Instr       (Instr),
    .pc_plus2    (pc_plus2),
    .instr_valid (instr_valid),
    .id_stall    (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA500;
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: done after mem_lat cycles of imem_rd (0/1 = zero-wait).
  initial begin
    forever begin
      @(negedge clk);
      if (imem_rd) begin
        imem_rdata = (halt_en && imem_addr == 16'h0006) ? 16'h0000 : mem_word(imem_addr);
        if (mem_lat <= 1 || lat_cnt == mem_lat - 1) begin
          imem_done = 1'b1;
          lat_cnt   = 0;
        end else begin
          imem_done = 1'b0;
          lat_cnt++;
        end
      end else begin
        imem_done = 1'b0;
        lat_cnt   = 0;
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    id_stall    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_done   = 1'b0;
    imem_rdata  = 16'h0000;

    // Reset values
    tick();
    tick();
    check_eq("rst_rd",     16'(imem_rd),     16'h0000);
    check_eq("rst_addr",   imem_addr,        16'h0000);
    check_eq("rst_instr",  Instr,            16'h0800);
    check_eq("rst_pc2",    pc_plus2,         16'h0000);
    check_eq("rst_valid",  16'(instr_valid), 16'h0000);
    check_eq("rst_halted", 16'(halted),      16'h0000);

    // Zero-wait streaming
    rst_n = 1'b1;
    tick();
    check_eq("e1_rd",    16'(imem_rd),     16'h0001);
    check_eq("e1_addr",  imem_addr,        16'h0000);
    check_eq("e1_valid", 16'(instr_valid), 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("str_instr", Instr,            mem_word(16'(2 * k)));
      check_eq("str_pc2",   pc_plus2,         16'(2 * k + 2));
      check_eq("str_valid", 16'(instr_valid), 16'h0001);
    end

    // Stall: queue fills, request stops, head held
    id_stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      check_eq("stl_instr", Instr,        mem_word(16'h0006));
      check_eq("stl_pc2",   pc_plus2,     16'h0008);
      check_eq("stl_rd",    16'(imem_rd), 16'h0000);
    end
    id_stall = 1'b0;
    tick();
    check_eq("rel_instr", Instr,        mem_word(16'h0008));
    check_eq("rel_pc2",   pc_plus2,     16'h000A);
    check_eq("rel_rd",    16'(imem_rd), 16'h0001);
    check_eq("rel_addr",  imem_addr,    16'h000A);
    tick();
    check_eq("rel2_instr", Instr,    mem_word(16'h000A));
    check_eq("rel2_pc2",   pc_plus2, 16'h000C);

    // 3-cycle memory, redirect while 0x0004 outstanding
    rst_n   = 1'b0;
    mem_lat = 3;
    #1;
    check_eq("arst_rd",    16'(imem_rd),     16'h0000);
    check_eq("arst_valid", 16'(instr_valid), 16'h0000);
    check_eq("arst_instr", Instr,            16'h0800);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    check_eq("lat_instr", Instr,        mem_word(16'h0002));
    check_eq("lat_pc2",   pc_plus2,     16'h0004);
    check_eq("lat_rd",    16'(imem_rd), 16'h0001);
    check_eq("lat_addr",  imem_addr,    16'h0004);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    check_eq("sq_valid", 16'(instr_valid), 16'h0000);
    check_eq("sq_instr", Instr,            16'h0800);
    check_eq("sq_rd",    16'(imem_rd),     16'h0001);
    check_eq("sq_addr",  imem_addr,        16'h0004);
    tick();
    check_eq("sq2_valid", 16'(instr_valid), 16'h0000);
    check_eq("sq2_addr",  imem_addr,        16'h0004);
    tick();
    check_eq("sq3_valid", 16'(instr_valid), 16'h0000);
    check_eq("sq3_rd",    16'(imem_rd),     16'h0001);
    check_eq("sq3_addr",  imem_addr,        16'h0100);
    tick();
    check_eq("sq4_valid", 16'(instr_valid), 16'h0000);
    tick();
    check_eq("sq5_valid", 16'(instr_valid), 16'h0000);
    tick();
    check_eq("tgt_instr", Instr,            16'hA400);
    check_eq("tgt_pc2",   pc_plus2,         16'h0102);
    check_eq("tgt_valid", 16'(instr_valid), 16'h0001);

    // Redirect coinciding with done and pop; odd target
    mem_lat = 0;
    tick();
    check_eq("zw_instr", Instr,    16'hA402);
    check_eq("zw_pc2",   pc_plus2, 16'h0104);
    redirect    = 1'b1;
    redirect_pc = 16'h0205;
    tick();
    redirect = 1'b0;
    check_eq("rdd_valid", 16'(instr_valid), 16'h0000);
    check_eq("rdd_instr", Instr,            16'h0800);
    check_eq("rdd_pc2",   pc_plus2,         16'h0000);
    check_eq("rdd_rd",    16'(imem_rd),     16'h0001);
    check_eq("rdd_addr",  imem_addr,        16'h0204);
    tick();
    check_eq("rdd2_instr", Instr,    16'hA704);
    check_eq("rdd2_pc2",   pc_plus2, 16'h0206);
    tick();
    check_eq("rdd3_instr", Instr,    16'hA706);
    check_eq("rdd3_pc2",   pc_plus2, 16'h0208);

    // HALT word at address 6
    rst_n   = 1'b0;
    halt_en = 1'b1;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    tick();
    check_eq("hlt_instr",  Instr,            16'h0000);
    check_eq("hlt_pc2",    pc_plus2,         16'h0008);
    check_eq("hlt_valid",  16'(instr_valid), 16'h0001);
    check_eq("hlt_halted", 16'(halted),      16'h0001);
    check_eq("hlt_rd",     16'(imem_rd),     16'h0000);
    for (int h = 0; h < 3; h++) begin
      tick();
      check_eq("hlt_idle_rd",     16'(imem_rd),     16'h0000);
      check_eq("hlt_idle_halted", 16'(halted),      16'h0001);
      check_eq("hlt_idle_valid",  16'(instr_valid), 16'h0000);
    end
    redirect    = 1'b1;
    redirect_pc = 16'h0020;
    tick();
    redirect = 1'b0;
    check_eq("unh_halted", 16'(halted),  16'h0000);
    check_eq("unh_rd",     16'(imem_rd), 16'h0000);
    tick();
    check_eq("unh2_rd",   16'(imem_rd), 16'h0001);
    check_eq("unh2_addr", imem_addr,    16'h0020);
    tick();
    check_eq("unh3_instr", Instr,            16'hA520);
    check_eq("unh3_pc2",   pc_plus2,         16'h0022);
    check_eq("unh3_valid", 16'(instr_valid), 16'h0001);

    // PC wrap at 16'hFFFE
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    check_eq("wrp_addr",  imem_addr,        16'hFFFE);
    check_eq("wrp_rd",    16'(imem_rd),     16'h0001);
    check_eq("wrp_valid", 16'(instr_valid), 16'h0000);
    tick();
    check_eq("wrp2_instr", Instr,            16'h5AFE);
    check_eq("wrp2_pc2",   pc_plus2,         16'h0000);
    check_eq("wrp2_valid", 16'(instr_valid), 16'h0001);
    check_eq("wrp2_addr",  imem_addr,        16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
